// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and default constants for the data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package dmem_pkg;

  // Default geometry: 64 words of 32 bits, two wait states per access.
  localparam int DMEM_DEPTH_DEFAULT = 64;
  localparam int DMEM_WAIT_DEFAULT  = 2;

  // Responder FSM: IDLE accepts, WAIT burns wait states, RESP holds the response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: DEPTH x 32-bit storage, asynchronous read, synchronous write.
// Latency: read is combinational; a write lands on the rising edge of i_clk.
// Backpressure: none; always ready.
// Ports: i_clk clock; i_we write enable; i_addr word index (shared by read and write);
//        i_wdata write data; o_rdata read data of the word at i_addr.
// Contents are not reset.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH_DEFAULT
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with a fixed number of wait states.
// Latency: resp_valid rises WAIT+1 cycles after the accept cycle; one idle bubble follows each response handshake.
// Backpressure: resp_* held stable until resp_ready; req_ready only in IDLE, so one request in flight.
// Ports: clk; reset (asynchronous, active-low); req_valid/req_ready/req_we/req_addr/req_wdata request channel;
//        resp_valid/resp_ready/resp_rdata/resp_err response channel.
// Optional feature: define DMEM_ERR_CHECK_EN to reject misaligned or out-of-range addresses via resp_err.
module dmem_responder #(
  parameter int DEPTH = dmem_pkg::DMEM_DEPTH_DEFAULT,
  parameter int WAIT  = dmem_pkg::DMEM_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  // The WAIT parameter shares its name with the WAIT state, so the state is
  // always written package-qualified and only the other names are imported.
  import dmem_pkg::dmem_state_t;
  import dmem_pkg::IDLE;
  import dmem_pkg::RESP;

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  dmem_state_t     r_state;
  dmem_state_t     w_state_nxt;
  logic [3:0]      r_cnt;
  logic [3:0]      w_cnt_nxt;
  logic            r_live;
  logic            r_we;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic            r_err;
  logic [31:0]     r_rdata;

  logic            w_idle;
  logic            w_accept;
  logic            w_enter_resp;
  logic            w_in_err;
  logic [AW-1:0]   w_in_idx;
  logic            w_cur_we;
  logic            w_cur_err;
  logic [AW-1:0]   w_cur_idx;
  logic [31:0]     w_cur_wdata;
  logic            w_ram_we;
  logic [31:0]     w_ram_rdata;

  assign w_idle   = (r_state == IDLE);
  // r_live keeps req_ready low while reset is held and until the first edge after release.
  assign req_ready = r_live & w_idle;
  assign w_accept  = req_valid & req_ready;

  assign w_in_idx = req_addr[AW+1:2];

`ifdef DMEM_ERR_CHECK_EN
  assign w_in_err = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= 30'(DEPTH));
`else
  // Byte-offset and upper address bits are ignored; the index wraps modulo DEPTH.
  logic w_unused_addr_bits;
  assign w_in_err           = 1'b0;
  assign w_unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};
`endif

  // With WAIT=0 the RAM access happens on the accept edge itself, before the
  // request registers load, so take the operands straight from the ports while idle.
  assign w_cur_we    = w_idle ? req_we    : r_we;
  assign w_cur_idx   = w_idle ? w_in_idx  : r_idx;
  assign w_cur_wdata = w_idle ? req_wdata : r_wdata;
  assign w_cur_err   = w_idle ? w_in_err  : r_err;

  // Stores commit only on the edge entering RESP, so a reset during WAIT drops them.
  assign w_ram_we = w_enter_resp & w_cur_we & ~w_cur_err;

  dmem_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_cur_idx),
    .i_wdata (w_cur_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (WAIT == 0) begin
            w_state_nxt  = RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = dmem_pkg::WAIT;
            w_cnt_nxt   = WAIT_LOAD;
          end
        end
      end
      dmem_pkg::WAIT: begin
        // Leave one cycle after the counter has reached zero.
        if (r_cnt == 4'd0) begin
          w_state_nxt  = RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_live  <= 1'b0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_live  <= 1'b1;
      if (w_accept) begin
        r_we    <= req_we;
        r_idx   <= w_in_idx;
        r_wdata <= req_wdata;
        r_err   <= w_in_err;
      end
      if (w_enter_resp) begin
        r_rdata <= (w_cur_we | w_cur_err) ? 32'd0 : w_ram_rdata;
      end
    end
  end

  assign resp_valid = (r_state == RESP);
  assign resp_rdata = resp_valid ? r_rdata : 32'd0;
  assign resp_err   = resp_valid & r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: two responders (WAIT=2 and WAIT=0, DEPTH=64) checked against a word-array model.
// Latency: expects resp_valid WAIT+1 cycles after accept, then a one-cycle bubble.
// Backpressure: holds resp_ready low for random spans and checks the response stays put.
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int W0    = 2;
  localparam int W1    = 0;
`ifdef DMEM_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  logic [31:0] mem [2][DEPTH];
  int n_cmp;
  int n_fail;

  dmem_responder #(.DEPTH(DEPTH), .WAIT(W0)) u_dut_w2 (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT(W1)) u_dut_w0 (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? W0 + 1 : W1 + 1;
  endfunction

  // One complete transaction with `hold` cycles of response back-pressure.
  task automatic run_txn(input int d, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int hold);
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          idx;
    int          lat;
    int          wait_n;
    idx       = int'((addr / 32'd4) % 32'(DEPTH));
    exp_err   = ERR_EN && ((addr[1:0] != 2'b00) || ((addr / 32'd4) >= 32'(DEPTH)));
    exp_rdata = (exp_err || we) ? 32'd0 : mem[d][idx];

    @(negedge clk);
    req_valid[d]  = 1'b1;
    req_we[d]     = we;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
    resp_ready[d] = 1'b0;
    wait_n = 0;
    while (req_ready[d] !== 1'b1 && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    check("accept_in_time", 32'(wait_n < 20), 32'd1);
    @(negedge clk);
    // Request captured; scramble the ports to show they are no longer used.
    req_valid[d] = 1'b0;
    req_we[d]    = ~we;
    req_addr[d]  = $urandom;
    req_wdata[d] = $urandom;
    lat = 1;
    while (resp_valid[d] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(lat_of(d)));
    for (int h = 0; h < hold; h++) begin
      check("hold_valid", 32'(resp_valid[d]), 32'd1);
      check("hold_rdata", resp_rdata[d], exp_rdata);
      check("hold_ready_low", 32'(req_ready[d]), 32'd0);
      @(negedge clk);
    end
    check("rdata", resp_rdata[d], exp_rdata);
    check("err", 32'(resp_err[d]), 32'(exp_err));
    check("ready_low_in_resp", 32'(req_ready[d]), 32'd0);
    resp_ready[d] = 1'b1;
    @(negedge clk);
    resp_ready[d] = 1'b0;
    check("valid_drop", 32'(resp_valid[d]), 32'd0);
    check("rdata_zero_idle", resp_rdata[d], 32'd0);
    check("ready_after_bubble", 32'(req_ready[d]), 32'd1);
    if (!exp_err && we) mem[d][idx] = wdata;
  endtask

  initial begin
    logic [31:0] addr;
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'd0;
      req_wdata[d] = 32'd0; resp_ready[d] = 1'b0;
    end

    // Reset held for three cycles.
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", 32'(req_ready[d]), 32'd0);
      check("rst_valid", 32'(resp_valid[d]), 32'd0);
      check("rst_rdata", resp_rdata[d], 32'd0);
      check("rst_err", 32'(resp_err[d]), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", 32'(req_ready[0]), 32'd0);
    @(negedge clk);
    check("ready_after_edge", 32'(req_ready[0]), 32'd1);
    check("ready_after_edge_w0", 32'(req_ready[1]), 32'd1);

    // Fill both memories so every later load has a known expectation.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++)
        run_txn(d, 1'b1, 32'(i * 4), $urandom, 0);

    // Store then load, WAIT=2.
    run_txn(0, 1'b1, 32'h64, 32'd7, 0);
    run_txn(0, 1'b0, 32'h64, 32'd0, 0);

    // Four cycles of response back-pressure.
    run_txn(0, 1'b1, 32'h10, 32'h12345678, 0);
    run_txn(0, 1'b0, 32'h10, 32'd0, 4);

    // WAIT=0 back-to-back loads with req_valid held high.
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h0; resp_ready[1] = 1'b1;
    check("b2b_ready", 32'(req_ready[1]), 32'd1);
    @(negedge clk);
    check("b2b_valid0", 32'(resp_valid[1]), 32'd1);
    check("b2b_rdata0", resp_rdata[1], mem[1][0]);
    check("b2b_busy0", 32'(req_ready[1]), 32'd0);
    req_addr[1] = 32'h4;
    @(negedge clk);
    check("b2b_bubble_valid", 32'(resp_valid[1]), 32'd0);
    check("b2b_bubble_ready", 32'(req_ready[1]), 32'd1);
    @(negedge clk);
    check("b2b_valid1", 32'(resp_valid[1]), 32'd1);
    check("b2b_rdata1", resp_rdata[1], mem[1][1]);
    req_valid[1] = 1'b0;
    @(negedge clk);
    check("b2b_done", 32'(resp_valid[1]), 32'd0);
    resp_ready[1] = 1'b0;

    // Reset during WAIT drops the pending store.
    run_txn(0, 1'b1, 32'h8, 32'h0BADF00D, 0);
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h8; req_wdata[0] = 32'h55;
    check("mid_rst_ready", 32'(req_ready[0]), 32'd1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(resp_valid[0]), 32'd0);
    check("mid_rst_ready_low", 32'(req_ready[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_idle", 32'(req_ready[0]), 32'd1);
    check("mid_rst_no_resp", 32'(resp_valid[0]), 32'd0);
    run_txn(0, 1'b0, 32'h8, 32'd0, 0);

    // Misaligned / out-of-range: rejected with the error build, wrapped otherwise.
    run_txn(0, 1'b1, 32'h65, 32'hAA, 0);
    run_txn(0, 1'b1, 32'h100, 32'hAA, 0);
    run_txn(0, 1'b1, 32'h165, 32'hAA, 0);
    run_txn(0, 1'b0, 32'h64, 32'd0, 0);
    run_txn(1, 1'b0, 32'h103, 32'd0, 1);

    // Random traffic on both responders.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) != 0) addr = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      else                          addr = $urandom;
      run_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr, $urandom,
              int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
